// File: rtl/zclock_gen.sv
// Z80 clock generator: zclk_out plus zpos/zneg strobes from the 28 MHz clock, N speed modes, wait/stall freeze.
// Latency: strobes appear the cycle after terminal count; zclk_out toggles at the end of an unstalled strobe cycle.
// Backpressure: cpu_stall / wait_req / wait counter freeze the divider; strobes are masked while frozen.
// Optional feature macro: ZCLOCK_TSTATE_CNT_EN (T-state counter on zpos).
module zclock_gen #(
    parameter int MODES      = 3,
    parameter int TW         = 2,
    parameter int IO_MODE    = 1,
    parameter int SLW        = 4,
    parameter int RST_MODE   = 0,
    parameter int ANY_SWITCH = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TW-1:0]  turbo,
    input  logic           rfsh,
    input  logic           iorq_s,
    input  logic           external_port,
    input  logic           cpu_stall,
    input  logic           wait_req,
    input  logic [SLW-1:0] wait_len,
`ifdef ZCLOCK_TSTATE_CNT_EN
    input  logic           tcnt_clr,
    output logic [15:0]    tstates,
`endif
    output logic           zclk_out,
    output logic           zpos,
    output logic           zneg,
    output logic [TW-1:0]  mode_cur,
    output logic           stalled
);
    localparam int HW = MODES;
    typedef logic [TW-1:0] mode_t;
    typedef logic [HW-1:0] cnt_t;

    function automatic cnt_t hp_of(input mode_t m);
        hp_of = cnt_t'(1) << (MODES - 1 - int'(m));
    endfunction

    logic [SLW-1:0] wcnt_q, wcnt_d;
    cnt_t           hc_q, hc_d, hp_len_q, hp_len_d, hp_use;
    mode_t          mode_q, mode_d, eff, turbo_cl;
    logic           zclk_q, zclk_d;
    logic           pos_q, pos_d, neg_q, neg_d;
    logic           stalled_q;
    logic           stall, strobe_q, term;

    assign stall    = cpu_stall | wait_req | (wcnt_q != '0);
    assign strobe_q = pos_q | neg_q;
    assign turbo_cl = (int'(turbo) >= MODES) ? mode_t'(MODES - 1) : turbo;

    always_comb begin
        mode_d = mode_q;
        if (neg_q && (rfsh || (ANY_SWITCH != 0)))
            mode_d = turbo_cl;
        eff = mode_d;
        if (iorq_s && external_port && (int'(mode_d) > IO_MODE))
            eff = mode_t'(IO_MODE);
        // The strobe cycle is the first counted cycle of the new half-period.
        hp_use = strobe_q ? hp_of(eff) : hp_len_q;
        term   = (hc_q == hp_use - cnt_t'(1));
    end

    always_comb begin
        wcnt_d   = wcnt_q;
        hc_d     = hc_q;
        hp_len_d = hp_len_q;
        zclk_d   = zclk_q;
        pos_d    = pos_q;
        neg_d    = neg_q;
        if (wait_req)
            wcnt_d = wait_len;
        else if (wcnt_q != '0)
            wcnt_d = wcnt_q - 1'b1;
        // A stall holds everything, including a pending strobe, which fires once unstalled.
        if (!stall) begin
            hp_len_d = hp_use;
            if (strobe_q)
                zclk_d = ~zclk_q;
            if (term) begin
                hc_d  = '0;
                pos_d = zclk_d;
                neg_d = ~zclk_d;
            end else begin
                hc_d  = hc_q + cnt_t'(1);
                pos_d = 1'b0;
                neg_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q    <= '0;
            hc_q      <= '0;
            hp_len_q  <= hp_of(mode_t'(RST_MODE));
            mode_q    <= mode_t'(RST_MODE);
            zclk_q    <= 1'b0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            hc_q      <= hc_d;
            hp_len_q  <= hp_len_d;
            zclk_q    <= zclk_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            stalled_q <= stall;
            if (!stall)
                mode_q <= mode_d;
        end
    end

    assign zclk_out = zclk_q;
    assign zpos     = pos_q & ~stall;
    assign zneg     = neg_q & ~stall;
    assign mode_cur = mode_q;
    assign stalled  = stalled_q;

`ifdef ZCLOCK_TSTATE_CNT_EN
    logic [15:0] tst_q;

    always_ff @(posedge clk) begin
        if (rst || tcnt_clr)
            tst_q <= '0;
        else if (zpos)
            tst_q <= tst_q + 16'd1;
    end

    assign tstates = tst_q;
`endif
endmodule

// File: tb/tb_zclock_gen.sv
// Bench for zclock_gen: constant vector table, directed corner sequences, and randomized cycles
// checked against a countdown-based model of the clock rules.
module tb_zclock_gen;
    localparam int MODES = 3, IO_MODE = 1, RST_MODE = 0, ANY_SWITCH = 0;

    logic       clk = 0;
    logic       rst, rfsh, iorq_s, external_port, cpu_stall, wait_req;
    logic [1:0] turbo;
    logic [3:0] wait_len;
    logic       zclk_out, zpos, zneg, stalled;
    logic [1:0] mode_cur;
`ifdef ZCLOCK_TSTATE_CNT_EN
    logic        tcnt_clr;
    logic [15:0] tstates;
`endif

    always #5 clk = ~clk;

    zclock_gen dut (
        .clk(clk), .rst(rst), .turbo(turbo), .rfsh(rfsh), .iorq_s(iorq_s),
        .external_port(external_port), .cpu_stall(cpu_stall), .wait_req(wait_req),
        .wait_len(wait_len),
`ifdef ZCLOCK_TSTATE_CNT_EN
        .tcnt_clr(tcnt_clr), .tstates(tstates),
`endif
        .zclk_out(zclk_out), .zpos(zpos), .zneg(zneg), .mode_cur(mode_cur), .stalled(stalled)
    );

    typedef struct {
        bit rst; bit [1:0] turbo; bit rfsh, iorq, ext, cstall, wreq; bit [3:0] wlen; bit tclr;
    } in_t;
    typedef struct {
        in_t i; bit zclk, zpos, zneg, stalled; bit [1:0] mode;
    } vec_t;

    int vectors = 0, miscompares = 0;
    in_t cur;
    bit s_zclk, s_zpos, s_zneg, s_stalled;
    int s_mode, s_tst;

    // Model: countdown of unstalled cycles to the next zclk edge.
    int m_rem, m_mode, m_wcnt, m_tst;
    bit m_lvl, m_stalled;

    function automatic int hp(input int t);
        return 1 << (MODES - 1 - t);
    endfunction

    task automatic model_reset();
        m_rem = hp(RST_MODE) + 1; m_mode = RST_MODE; m_lvl = 0;
        m_wcnt = 0; m_stalled = 0; m_tst = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit stall, e_pos, e_neg;
        int t, eff;
        rst = cur.rst; turbo = cur.turbo; rfsh = cur.rfsh; iorq_s = cur.iorq;
        external_port = cur.ext; cpu_stall = cur.cstall; wait_req = cur.wreq; wait_len = cur.wlen;
`ifdef ZCLOCK_TSTATE_CNT_EN
        tcnt_clr = cur.tclr;
`endif
        @(negedge clk);
        stall = cur.cstall || cur.wreq || (m_wcnt != 0);
        e_pos = 0; e_neg = 0;
        if (!stall) begin
            m_rem--;
            if (m_rem == 0) begin
                e_pos = m_lvl; e_neg = !m_lvl;
            end
        end
        s_zclk = zclk_out; s_zpos = zpos; s_zneg = zneg; s_stalled = stalled; s_mode = int'(mode_cur);
        if (!cur.rst) begin
            chk("zclk_out", int'(zclk_out), int'(m_lvl));
            chk("zpos", int'(zpos), int'(e_pos));
            chk("zneg", int'(zneg), int'(e_neg));
            chk("stalled", int'(stalled), int'(m_stalled));
            chk("mode_cur", int'(mode_cur), m_mode);
            if (zpos && zneg) chk("zpos_zneg_excl", 1, 0);
`ifdef ZCLOCK_TSTATE_CNT_EN
            s_tst = int'(tstates);
            chk("tstates", int'(tstates), m_tst);
`endif
        end
        @(posedge clk);
        if (cur.rst) model_reset();
        else begin
            m_stalled = stall;
            if (cur.wreq) m_wcnt = cur.wlen;
            else if (m_wcnt != 0) m_wcnt--;
            if (cur.tclr) m_tst = 0;
            else if (e_pos) m_tst = (m_tst + 1) & 16'hFFFF;
            if (e_pos || e_neg) begin
                if (e_neg && (cur.rfsh || ANY_SWITCH != 0)) begin
                    t = cur.turbo;
                    m_mode = (t >= MODES) ? MODES - 1 : t;
                end
                eff = (cur.iorq && cur.ext && m_mode > IO_MODE) ? IO_MODE : m_mode;
                m_rem = hp(eff);
                m_lvl = !m_lvl;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cur = '{default: 0};
        cur.rst = 1; step(); step();
        cur.rst = 0;
    endtask

    task automatic wait_strobe(input bit want_pos, input int budget);
        int n = 0;
        do begin
            step(); n++;
        end while (!(want_pos ? s_zpos : s_zneg) && n < budget);
        if (!(want_pos ? s_zpos : s_zneg)) chk("strobe_timeout", 0, 1);
    endtask

    function automatic vec_t mk(bit wreq, bit [3:0] wlen, bit zc, bit zp, bit zn, bit st);
        vec_t v;
        v.i = '{default: 0};
        v.i.wreq = wreq; v.i.wlen = wlen;
        v.zclk = zc; v.zpos = zp; v.zneg = zn; v.stalled = st; v.mode = 2'(RST_MODE);
        return v;
    endfunction

    vec_t tbl[15];
    int cnt, cnt2;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 0);

        cur = '{default: 0};
        model_reset();
        #1;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            cur = tbl[k].i;
            step();
            chk($sformatf("tbl%0d_zclk", k), int'(s_zclk), int'(tbl[k].zclk));
            chk($sformatf("tbl%0d_zpos", k), int'(s_zpos), int'(tbl[k].zpos));
            chk($sformatf("tbl%0d_zneg", k), int'(s_zneg), int'(tbl[k].zneg));
            chk($sformatf("tbl%0d_stalled", k), int'(s_stalled), int'(tbl[k].stalled));
            chk($sformatf("tbl%0d_mode", k), s_mode, int'(tbl[k].mode));
        end

        // wait_len=5 mid-half-period: 6 frozen cycles, stalled visible one cycle later for 6.
        do_reset();
        wait_strobe(0, 20);
        step(); step();
        cur.wreq = 1; cur.wlen = 5; step();
        cnt = int'(s_zpos) + int'(s_zneg);
        cur.wreq = 0;
        cnt2 = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) cnt += int'(s_zpos) + int'(s_zneg);
            step();
            cnt2 += int'(s_stalled);
            if (k < 5) cnt += int'(s_zpos) + int'(s_zneg);
        end
        chk("wait5_no_strobes", cnt, 0);
        chk("wait5_stalled_cycles", cnt2, 6);
        step();
        chk("wait5_stalled_drop", int'(s_stalled), 0);

        // Overwrite: 7 then 2 three cycles later; rst in a stall.
        cur.wreq = 1; cur.wlen = 7; step();
        cur.wreq = 0; step(); step();
        cur.wreq = 1; cur.wlen = 2; step();
        cur.wreq = 0; step(); step(); step(); step();
        chk("overwrite_stalled_end", int'(s_stalled), 0);
        cur.wreq = 1; cur.wlen = 7; step();
        cur.wreq = 0; step();
        cur.rst = 1; step();
        cur.rst = 0; step();
        chk("rst_stall_stalled", int'(s_stalled), 0);
        chk("rst_stall_zclk", int'(s_zclk), 0);
        chk("rst_stall_mode", s_mode, RST_MODE);

        // Pending mode change without refresh, then taken at the first zneg with rfsh.
        cur.turbo = 2;
        for (int k = 0; k < 100; k++) step();
        chk("mode_pending", s_mode, 0);
        cur.rfsh = 1;
        wait_strobe(0, 20);
        cur.rfsh = 0;
        step();
        chk("mode_switched", s_mode, 2);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(); cnt += int'(s_zpos) + int'(s_zneg); end
        chk("mode2_strobes_8", cnt, 8);

        // External IO fallback to IO_MODE and release.
        cur.iorq = 1; cur.ext = 1;
        for (int k = 0; k < 12; k++) step();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(); cnt += int'(s_zpos) + int'(s_zneg); end
        chk("io_fallback_strobes_8", cnt, 4);
        cur.iorq = 0;
        for (int k = 0; k < 6; k++) step();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(); cnt += int'(s_zpos) + int'(s_zneg); end
        chk("io_release_strobes_8", cnt, 8);
        cur.ext = 0;

`ifdef ZCLOCK_TSTATE_CNT_EN
        cur.tclr = 1; step();
        cur.tclr = 0;
        for (int k = 0; k < 21; k++) step();
        chk("tstates_20cyc", s_tst, 10);
        wait_strobe(0, 10);
        cur.tclr = 1; step();
        cur.tclr = 0; step();
        chk("tstates_clr_wins", s_tst, 0);
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cur.rst    = ($urandom_range(0, 199) == 0);
            cur.turbo  = 2'($urandom_range(0, 3));
            cur.rfsh   = ($urandom_range(0, 3) == 0);
            cur.iorq   = ($urandom_range(0, 2) == 0);
            cur.ext    = ($urandom_range(0, 1) == 0);
            cur.cstall = ($urandom_range(0, 7) == 0);
            cur.wreq   = ($urandom_range(0, 19) == 0);
            cur.wlen   = 4'($urandom_range(0, 15));
            cur.tclr   = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
